imem_loader: RTL

- Write-side counterpart to the instruction fetch stage: loads a program into instruction memory BRAM port A (clka/ena/wea/addra/dina), which fetch leaves tied off.
- Receives a framed byte stream over valid/ready: 16-bit word count, 4N little-endian instruction bytes, XOR checksum byte.
- Holds the processor (cpu_hold) until a load completes cleanly.

---
 rtl/imem_loader_if.sv | 24 ++
 rtl/imem_loader.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and BRAM port-A write bus for the instruction memory loader.
// The stream source drives rx_data/rx_valid; the loader drives everything else.
`timescale 1ns/1ps
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a framed program (16-bit word count, little-endian words, XOR checksum)
// into instruction memory port A and holds the CPU until a clean load completes.
`timescale 1ns/1ps
module imem_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  imem_loader_if.slave        bus,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                cpu_hold,
  output logic [ADDR_WIDTH:0] word_count
);

  localparam int CW = 17;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  state_e                state_q;
  logic [15:0]           len_q;
  logic [1:0]            byte_idx_q;
  logic [23:0]           word_q;
  logic [7:0]            csum_q;
  logic                  rx_ready_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_wdata_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  error_q;
  logic                  cpu_hold_q;
  logic [ADDR_WIDTH:0]   word_count_q;

  logic                  accept_d;
  logic [15:0]           len_d;
  logic                  len_bad_d;
  logic [7:0]            csum_d;
  logic                  last_word_d;

  assign accept_d    = bus.rx_valid && rx_ready_q;
  assign len_d       = {bus.rx_data, len_q[7:0]};
  assign len_bad_d   = (len_d == 16'd0) || (32'(len_d) > 32'(DEPTH));
  assign csum_d      = csum_q ^ bus.rx_data;
  // word_count already reflects every earlier word when the 4th byte of this one lands
  assign last_word_d = (CW'(word_count_q) + CW'(1)) == CW'(len_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      byte_idx_q   <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      rx_ready_q   <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      cpu_hold_q   <= 1'b1;
      word_count_q <= '0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q      <= S_LEN0;
            rx_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
            byte_idx_q   <= '0;
            csum_q       <= '0;
          end
        end
        S_LEN0: begin
          if (accept_d) begin
            len_q[7:0] <= bus.rx_data;
            state_q    <= S_LEN1;
          end
        end
        S_LEN1: begin
          if (accept_d) begin
            len_q <= len_d;
            if (len_bad_d) begin
              state_q    <= S_ERR;
              rx_ready_q <= 1'b0;
              busy_q     <= 1'b0;
              error_q    <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept_d) begin
            csum_q     <= csum_d;
            byte_idx_q <= byte_idx_q + 2'd1;
            case (byte_idx_q)
              2'd0: word_q[7:0]   <= bus.rx_data;
              2'd1: word_q[15:8]  <= bus.rx_data;
              2'd2: word_q[23:16] <= bus.rx_data;
              default: begin
                mem_en_q     <= 1'b1;
                mem_we_q     <= 1'b1;
                mem_addr_q   <= word_count_q[ADDR_WIDTH-1:0];
                mem_wdata_q  <= {bus.rx_data, word_q};
                word_count_q <= word_count_q + 1'b1;
                if (last_word_d) begin
                  state_q <= S_CSUM;
                end
              end
            endcase
          end
        end
        S_CSUM: begin
          if (accept_d) begin
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            if (bus.rx_data == csum_q) begin
              state_q    <= S_DONE;
              done_q     <= 1'b1;
              cpu_hold_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              error_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready  = rx_ready_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign cpu_hold      = cpu_hold_q;
  assign word_count    = word_count_q;

endmodule
